// File: rtl/otp_pkg.sv
// Shared types and helpers for the OTP macro model and its access controller.
package otp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    PG   = 2'd2,
    DONE = 2'd3
  } otp_state_e;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

  // Mask with the low w bits set; callers cast it down to their word width.
  function automatic logic [63:0] all_ones(input int unsigned w);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/otp_pulse_timer.sv
// Load/count-down/expire timer shared by the read-latency and program-pulse phases.
module otp_pulse_timer #(
  parameter int CW = 3
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_expire
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (r_cnt == CW'(1));

endmodule

// File: rtl/otp_mem_ctrl.sv
// OTP fuse array model plus req/ack access controller (read, OR-only program, lockout).
// Optional build macro OTP_BLANK_CHECK_EN: only blank (INIT_VAL) words may be programmed.
module otp_mem_ctrl
  import otp_pkg::*;
#(
  parameter int             DW       = 8,
  parameter int             DEPTH    = 128,
  parameter int             RD_LAT   = 2,
  parameter int             PROG_CYC = 4,
  parameter logic [DW-1:0]  INIT_VAL = '0,
  localparam int            AW       = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          wrong,
  output logic          busy,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam int            MAXC = (RD_LAT > PROG_CYC) ? RD_LAT : PROG_CYC;
  localparam int            CW   = $clog2(MAXC + 1);
  localparam logic [DW-1:0] ONES = DW'(all_ones(DW));

  otp_state_e    r_state, w_state_next;
  logic          w_load, w_expire, w_in_oor, w_blank_ok, w_pg_ok, w_we_mem;
  logic [CW-1:0] w_load_val;
  logic [AW-1:0] w_in_idx, w_rd_idx, r_idx;
  logic          r_oor, r_wrong, r_err;
  logic [DW-1:0] r_wdata, r_rd_q, r_rdata, w_cur;

  // The array stores word ^ INIT_VAL so that a zero power-up image reads back as blank.
  logic [DW-1:0] mem [0:DEPTH-1];

  assign w_in_oor = ({1'b0, addr} >= (AW+1)'(DEPTH));
  assign w_in_idx = w_in_oor ? '0 : addr;
  assign w_rd_idx = (r_state == IDLE) ? w_in_idx : r_idx;
  assign w_cur    = r_rd_q ^ INIT_VAL;
  assign w_load_val = we ? CW'(PROG_CYC) : CW'(RD_LAT);

`ifdef OTP_BLANK_CHECK_EN
  assign w_blank_ok = (w_cur == INIT_VAL);
`else
  assign w_blank_ok = 1'b1;
`endif

  assign w_pg_ok  = !r_wrong && !r_oor && w_blank_ok;
  assign w_we_mem = (r_state == PG) && w_expire && w_pg_ok && !rst;

  otp_pulse_timer #(.CW(CW)) u_timer (
    .pclk       (pclk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    busy         = (r_state != IDLE);
    ack          = (r_state == DONE);
    case (r_state)
      IDLE: if (req) begin
        w_load       = 1'b1;
        w_state_next = we ? PG : RD;
      end
      RD, PG: if (w_expire) w_state_next = DONE;
      DONE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Read-first port: r_rd_q tracks the addressed word every cycle, the write lands on the last PG cycle.
  always_ff @(posedge pclk) begin
    if (w_we_mem) mem[r_idx] <= (w_cur | r_wdata) ^ INIT_VAL;
    r_rd_q <= mem[w_rd_idx];
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_wrong <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= ERR_NONE;
    end else begin
      if (w_load) begin
        r_idx   <= w_in_idx;
        r_oor   <= w_in_oor;
        r_wrong <= wrong;
        r_wdata <= wdata;
      end
      if ((r_state == RD) && w_expire) begin
        if (r_oor) begin
          r_rdata <= ONES;
          r_err   <= ERR_FAIL;
        end else if (r_wrong) begin
          r_rdata <= ONES;
          r_err   <= ERR_NONE;
        end else begin
          r_rdata <= w_cur;
          r_err   <= ERR_NONE;
        end
      end
      if ((r_state == PG) && w_expire) r_err <= w_pg_ok ? ERR_NONE : ERR_FAIL;
    end
  end

  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

// File: tb/tb_otp_mem_ctrl.sv
// Self-checking bench for otp_mem_ctrl against a word-level fuse model (DEPTH=100 instance).
module tb_otp_mem_ctrl;

  localparam int DW = 8, DEPTH = 100, AW = 7, RD_LAT = 2, PROG_CYC = 4;
`ifdef OTP_BLANK_CHECK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wrong;
  } txn_t;

  logic pclk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, wrong = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic busy, ack, err;
  logic [DW-1:0] rdata;

  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] model [0:DEPTH-1];
  logic [DW-1:0] exp_rdata = '0;

  always #5 pclk = ~pclk;

  otp_mem_ctrl #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .PROG_CYC(PROG_CYC), .INIT_VAL(8'h00)) dut (
    .pclk(pclk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wrong(wrong),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err)
  );

  // Fuse rules: reads see the word (or all ones when locked/out of range); programs OR in unless rejected.
  task automatic model_step(input txn_t t, output logic [DW-1:0] e_rd, output logic e_err, output int e_lat);
    bit oor;
    oor   = (int'(t.addr) >= DEPTH);
    e_lat = t.we ? PROG_CYC + 1 : RD_LAT + 1;
    if (!t.we) begin
      if (oor)          begin e_rd = 8'hFF; e_err = 1'b1; end
      else if (t.wrong) begin e_rd = 8'hFF; e_err = 1'b0; end
      else              begin e_rd = model[t.addr]; e_err = 1'b0; end
      exp_rdata = e_rd;
    end else begin
      e_rd = exp_rdata;
      if (oor || t.wrong)                      e_err = 1'b1;
      else if (BLANK && model[t.addr] != 8'h00) e_err = 1'b1;
      else begin
        model[t.addr] = model[t.addr] | t.wdata;
        e_err = 1'b0;
      end
    end
  endtask

  // Drives one request from IDLE and reports what the DUT did; lat=0 means no ack within budget.
  task automatic run_txn(input txn_t t, output int lat, output int busy_cyc, output logic [DW-1:0] o_rd,
                         output logic o_err, output bit framed);
    logic [DW-1:0] pre_rd;
    logic pre_err;
    bit stable;
    pre_rd = rdata; pre_err = err; stable = 1'b1; lat = 0; busy_cyc = 0;
    req = 1'b1; we = t.we; addr = t.addr; wdata = t.wdata; wrong = t.wrong;
    @(posedge pclk); #1;
    req = 1'b0; we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); wrong = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cyc++;
      if (ack) begin lat = i; break; end
      if (rdata !== pre_rd || err !== pre_err) stable = 1'b0;
      @(posedge pclk); #1;
    end
    o_rd = rdata; o_err = err;
    @(posedge pclk); #1;
    framed = stable && (ack === 1'b0) && (busy === 1'b0);
    wrong = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    n_checks++;
    if ({busy, ack, rdata, err} !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b ack=%b rdata=%h err=%b want all 0", busy, ack, rdata, err);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_blank_read();
    txn_t t; int lat, bc, el; logic [DW-1:0] rd, erd; logic e, ee; bit fr;
    t = '{we: 1'b0, addr: 7'd7, wdata: 8'h00, wrong: 1'b0};
    run_txn(t, lat, bc, rd, e, fr);
    model_step(t, erd, ee, el);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL blank_lat: got %0d want 3", lat); end
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL blank_busy_cycles: got %0d want 3", bc); end
    n_checks++; if (rd !== 8'h00 || e !== 1'b0) begin n_fail++; $display("FAIL blank_data: got %h/%b want 00/0", rd, e); end
    n_checks++; if (!fr) begin n_fail++; $display("FAIL blank_framing: got 0 want 1"); end
    $display("txn blank_read addr=7 lat=%0d rdata=%h err=%b", lat, rd, e);
  endtask

  task automatic test_program_read();
    txn_t tab [3]; int lat, bc, el; logic [DW-1:0] rd, erd; logic e, ee; bit fr;
    tab[0] = '{we: 1'b1, addr: 7'd3, wdata: 8'h5A, wrong: 1'b0};
    tab[1] = '{we: 1'b1, addr: 7'd3, wdata: 8'h81, wrong: 1'b0};
    tab[2] = '{we: 1'b0, addr: 7'd3, wdata: 8'h00, wrong: 1'b0};
    for (int k = 0; k < 3; k++) begin
      run_txn(tab[k], lat, bc, rd, e, fr);
      model_step(tab[k], erd, ee, el);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL prog_lat[%0d]: got %0d want %0d", k, lat, el); end
      n_checks++; if (rd !== erd || e !== ee) begin n_fail++; $display("FAIL prog_data[%0d]: got %h/%b want %h/%b", k, rd, e, erd, ee); end
      n_checks++; if (!fr) begin n_fail++; $display("FAIL prog_framing[%0d]: got 0 want 1", k); end
      if (k == 1) begin
        n_checks++; if (e !== BLANK) begin n_fail++; $display("FAIL prog_second_err: got %b want %b", e, BLANK); end
      end
      if (k == 2) begin
        n_checks++;
        if (rd !== (BLANK ? 8'h5A : 8'hDB)) begin n_fail++; $display("FAIL prog_final_word: got %h want %h", rd, BLANK ? 8'h5A : 8'hDB); end
      end
      $display("txn program_read k=%0d we=%b addr=3 lat=%0d rdata=%h err=%b", k, tab[k].we, lat, rd, e);
    end
  endtask

  task automatic test_lockout();
    txn_t tab [3]; int lat, bc, el; logic [DW-1:0] rd, erd; logic e, ee; bit fr;
    tab[0] = '{we: 1'b1, addr: 7'd9, wdata: 8'hFF, wrong: 1'b1};
    tab[1] = '{we: 1'b0, addr: 7'd9, wdata: 8'h00, wrong: 1'b0};
    tab[2] = '{we: 1'b0, addr: 7'd9, wdata: 8'h00, wrong: 1'b1};
    for (int k = 0; k < 3; k++) begin
      run_txn(tab[k], lat, bc, rd, e, fr);
      model_step(tab[k], erd, ee, el);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL lock_lat[%0d]: got %0d want %0d", k, lat, el); end
      n_checks++; if (rd !== erd || e !== ee) begin n_fail++; $display("FAIL lock_data[%0d]: got %h/%b want %h/%b", k, rd, e, erd, ee); end
      n_checks++; if (!fr) begin n_fail++; $display("FAIL lock_framing[%0d]: got 0 want 1", k); end
      $display("txn lockout k=%0d we=%b wrong=%b lat=%0d rdata=%h err=%b", k, tab[k].we, tab[k].wrong, lat, rd, e);
    end
  endtask

  task automatic test_out_of_range();
    txn_t tab [6]; int lat, bc, el; logic [DW-1:0] rd, erd; logic e, ee; bit fr;
    tab[0] = '{we: 1'b0, addr: 7'd120, wdata: 8'h00, wrong: 1'b0};
    tab[1] = '{we: 1'b1, addr: 7'd120, wdata: 8'hA5, wrong: 1'b0};
    tab[2] = '{we: 1'b0, addr: 7'd0,   wdata: 8'h00, wrong: 1'b0};
    tab[3] = '{we: 1'b0, addr: 7'd20,  wdata: 8'h00, wrong: 1'b0};
    tab[4] = '{we: 1'b0, addr: 7'd56,  wdata: 8'h00, wrong: 1'b0};
    tab[5] = '{we: 1'b0, addr: 7'd100, wdata: 8'h00, wrong: 1'b0};
    for (int k = 0; k < 6; k++) begin
      run_txn(tab[k], lat, bc, rd, e, fr);
      model_step(tab[k], erd, ee, el);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL oor_lat[%0d]: got %0d want %0d", k, lat, el); end
      n_checks++; if (rd !== erd || e !== ee) begin n_fail++; $display("FAIL oor_data[%0d]: got %h/%b want %h/%b", k, rd, e, erd, ee); end
      $display("txn out_of_range k=%0d we=%b addr=%0d lat=%0d rdata=%h err=%b", k, tab[k].we, tab[k].addr, lat, rd, e);
    end
  endtask

  task automatic test_reset_abort();
    txn_t t; int lat, bc, el; logic [DW-1:0] rd, erd; logic e, ee; bit fr, saw_ack;
    t = '{we: 1'b0, addr: 7'd3, wdata: 8'h00, wrong: 1'b0};
    run_txn(t, lat, bc, rd, e, fr);
    model_step(t, erd, ee, el);
    n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL abort_pre_read: got %h want %h", rd, erd); end
    // Program addr 2, then reset during the third PG cycle.
    req = 1'b1; we = 1'b1; addr = 7'd2; wdata = 8'h0F; wrong = 1'b0;
    @(posedge pclk); #1 req = 1'b0;
    repeat (2) begin @(posedge pclk); #1; end
    rst = 1'b1; #1;
    n_checks++;
    if ({busy, ack, rdata, err} !== 11'd0) begin
      n_fail++; $display("FAIL abort_pg_outputs: got busy=%b ack=%b rdata=%h err=%b want all 0", busy, ack, rdata, err);
    end
    saw_ack = 1'b0;
    repeat (6) begin @(posedge pclk); #1 if (ack) saw_ack = 1'b1; end
    rst = 1'b0; exp_rdata = 8'h00;
    repeat (4) begin @(posedge pclk); #1 if (ack) saw_ack = 1'b1; end
    n_checks++; if (saw_ack) begin n_fail++; $display("FAIL abort_pg_ack: got ack want none"); end
    t = '{we: 1'b0, addr: 7'd2, wdata: 8'h00, wrong: 1'b0};
    run_txn(t, lat, bc, rd, e, fr);
    model_step(t, erd, ee, el);
    n_checks++; if (lat !== 3 || rd !== 8'h00 || e !== 1'b0) begin n_fail++; $display("FAIL abort_pg_word: got lat=%0d %h/%b want 3 00/0", lat, rd, e); end
    $display("txn reset_abort_pg addr=2 readback=%h", rd);
    // Abort a read of a programmed word after its first RD cycle.
    req = 1'b1; we = 1'b0; addr = 7'd3;
    @(posedge pclk); #1 req = 1'b0;
    rst = 1'b1;
    saw_ack = 1'b0;
    repeat (2) begin @(posedge pclk); #1 if (ack) saw_ack = 1'b1; end
    rst = 1'b0;
    repeat (4) begin @(posedge pclk); #1 if (ack) saw_ack = 1'b1; end
    n_checks++; if (saw_ack || rdata !== 8'h00) begin n_fail++; $display("FAIL abort_rd: got ack=%b rdata=%h want no ack, 00", saw_ack, rdata); end
    $display("txn reset_abort_rd addr=3 rdata=%h", rdata);
  endtask

  task automatic test_random();
    txn_t t; int lat, bc, el; logic [DW-1:0] rd, erd; logic e, ee; bit fr;
    for (int k = 0; k < 40; k++) begin
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(100, 127)) : AW'($urandom_range(0, 15));
      t.wdata = DW'($urandom & $urandom);
      t.wrong = ($urandom_range(0, 7) == 0);
      run_txn(t, lat, bc, rd, e, fr);
      model_step(t, erd, ee, el);
      n_checks++;
      if (lat !== el || rd !== erd || e !== ee || !fr) begin
        n_fail++; $display("FAIL rand[%0d]: got lat=%0d %h/%b framed=%b want lat=%0d %h/%b framed=1", k, lat, rd, e, fr, el, erd, ee);
      end
      $display("txn rand k=%0d we=%b addr=%0d wdata=%h wrong=%b lat=%0d rdata=%h err=%b", k, t.we, t.addr, t.wdata, t.wrong, lat, rd, e);
    end
  endtask

  // req held high: accepts land on edges 0,4,8,12 and acks are seen two edges after each.
  task automatic test_busy_collision();
    logic [AW-1:0] a [17];
    bit exp_ack;
    for (int m = 0; m < 17; m++) a[m] = AW'($urandom_range(0, 15));
    req = 1'b1; we = 1'b0; wrong = 1'b0; addr = a[0];
    for (int m = 0; m < 16; m++) begin
      @(posedge pclk); #1;
      addr = a[m+1];
      exp_ack = ((m % 4) == 2);
      n_checks++;
      if (ack !== exp_ack) begin n_fail++; $display("FAIL collide_ack[%0d]: got %b want %b", m, ack, exp_ack); end
      if (exp_ack) begin
        n_checks++;
        if (rdata !== model[a[m-2]]) begin n_fail++; $display("FAIL collide_data[%0d]: got %h want %h", m, rdata, model[a[m-2]]); end
        $display("txn collide edge=%0d addr=%0d rdata=%h", m, a[m-2], rdata);
      end
    end
    req = 1'b0;
    exp_rdata = model[a[12]];
    @(posedge pclk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL collide_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    test_reset();
    test_blank_read();
    test_program_read();
    test_lockout();
    test_out_of_range();
    test_reset_abort();
    test_random();
    test_busy_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
